// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like master port between an instruction-fetch
// requester (i_*) and a load/store requester (d_*). Only one transaction is
// outstanding on the master port at a time. Data requests win ties, but a
// fairness counter hands the port to a waiting fetch after FAIR_N consecutive
// data grants.
//
// Handshake: a requester is accepted in the IDLE cycle where its *_addr_ok is
// high. The request fields are latched at that point, so the requester may
// drop or change them afterwards. m_req stays high in ADDR until m_addr_ok is
// sampled high on a rising edge. The FSM then waits in DATA for m_data_ok and
// returns the word through the owner's *_data_ok for exactly one cycle (RESP).
// m_addr_ok outside ADDR and m_data_ok outside DATA are ignored.
module sram_arbiter #(
  parameter logic [31:0] DEV_BASE = 32'h1FAF_0000,
  parameter logic [31:0] DEV_MASK = 32'hFFFF_0000,
  parameter int          FAIR_N   = 4
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  // instruction fetch
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  // load / store
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [31:0] d_rdata,
  output logic        d_device,
  // shared master
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int FAIR_W = $clog2(FAIR_N + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [FAIR_W-1:0] fair_q, fair_d;
  logic              owner_d_q;   // 1: the data port owns the current transaction
  logic              gnt_d, gnt_i;
  logic              m_wr_q;
  logic [1:0]        m_size_q;
  logic [31:0]       m_addr_q, m_wdata_q;
  logic [31:0]       i_rdata_q, d_rdata_q;
  logic              d_device_q;

  // Arbitration: data first unless it has hogged the port while a fetch waits.
  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    if ((state_q == S_IDLE) && !cpu_rst) begin
      if (d_req && ((fair_q < FAIR_MAX) || !i_req)) begin
        gnt_d = 1'b1;
      end else if (i_req) begin
        gnt_i = 1'b1;
      end
    end
  end

  // Fairness counter next value: count data grants made over a pending fetch.
  always_comb begin
    fair_d = fair_q;
    if (gnt_d) begin
      if (!i_req) begin
        fair_d = '0;
      end else if (fair_q < FAIR_MAX) begin
        fair_d = fair_q + 1'b1;
      end
    end else if (gnt_i) begin
      fair_d = '0;
    end
  end

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transaction walks IDLE -> ADDR -> DATA -> RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (gnt_d || gnt_i) state_d = S_ADDR;
      S_ADDR: if (m_addr_ok)      state_d = S_DATA;
      S_DATA: if (m_data_ok)      state_d = S_RESP;
      S_RESP:                     state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state and the grant.
  always_comb begin
    i_addr_ok = gnt_i;
    d_addr_ok = gnt_d;
    m_req     = (state_q == S_ADDR);
    busy      = (state_q != S_IDLE);
    i_data_ok = (state_q == S_RESP) && !owner_d_q;
    d_data_ok = (state_q == S_RESP) &&  owner_d_q;
  end

  // Latch the granted request, track ownership, fairness and device flag.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      fair_q     <= '0;
      owner_d_q  <= 1'b0;
      m_wr_q     <= 1'b0;
      m_size_q   <= 2'b00;
      m_addr_q   <= 32'h0;
      m_wdata_q  <= 32'h0;
      d_device_q <= 1'b0;
    end else begin
      fair_q <= fair_d;
      if (gnt_d) begin
        owner_d_q  <= 1'b1;
        m_wr_q     <= d_wr;
        m_size_q   <= d_size;
        m_addr_q   <= d_addr;
        m_wdata_q  <= d_wdata;
        d_device_q <= ((d_addr & DEV_MASK) == DEV_BASE);
      end else if (gnt_i) begin
        owner_d_q <= 1'b0;
        m_wr_q    <= 1'b0;
        m_size_q  <= 2'b10;
        m_addr_q  <= i_addr;
        m_wdata_q <= 32'h0;
      end
    end
  end

  // Capture the returned word into the owner's response register; it holds
  // until that requester's next response.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else if ((state_q == S_DATA) && m_data_ok) begin
      if (owner_d_q) begin
        d_rdata_q <= m_rdata;
      end else begin
        i_rdata_q <= m_rdata;
      end
    end
  end

  assign m_wr     = m_wr_q;
  assign m_size   = m_size_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign d_device = d_device_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch-only, simultaneous requests,
// fairness, store/device flag, slow address phase with stray pulses and
// reset in the middle of a transaction. Expected read words are queued at
// accept time and popped when the requester's data_ok appears.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_addr_ok, i_data_ok;
  logic [31:0] i_rdata;
  logic        d_req, d_wr;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_addr_ok, d_data_ok;
  logic [31:0] d_rdata;
  logic        d_device;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  sram_arbiter #(
    .DEV_BASE(32'h1FAF_0000),
    .DEV_MASK(32'hFFFF_0000),
    .FAIR_N  (4)
  ) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_addr_ok  (i_addr_ok),
    .i_data_ok  (i_data_ok),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_wr       (d_wr),
    .d_size     (d_size),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_addr_ok  (d_addr_ok),
    .d_data_ok  (d_data_ok),
    .d_rdata    (d_rdata),
    .d_device   (d_device),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_size     (m_size),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_addr_ok  (m_addr_ok),
    .m_data_ok  (m_data_ok),
    .m_rdata    (m_rdata),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction starting at drive time of an IDLE cycle whose
  // request inputs the caller has already set. exp_d selects which port is
  // expected to win; the address phase lasts adly+1 cycles and the data
  // phase ddly+1 cycles.
  task automatic txn(input bit exp_d, input logic [31:0] a, input logic w,
                     input logic [1:0] sz, input logic [31:0] wd,
                     input logic [31:0] rd, input int adly, input int ddly,
                     input bit stray, input bit drop);
    logic [31:0] exp_word;
    #1;
    chk1("grant_i", i_addr_ok, !exp_d);
    chk1("grant_d", d_addr_ok, exp_d);
    chk1("idle_busy", busy, 1'b0);
    exp_q.push_back(rd);
    tick();
    if (drop) begin
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
    end
    i_addr  = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    for (int k = 0; k <= adly; k++) begin
      m_addr_ok = (k == adly);
      m_data_ok = stray && (k == 0) && (adly > 0);
      #1;
      chk1 ("addr_mreq",  m_req, 1'b1);
      chk32("addr_maddr", m_addr, a);
      chk1 ("addr_mwr",   m_wr, w);
      chk32("addr_msize", {30'h0, m_size}, {30'h0, sz});
      chk32("addr_mwdata", m_wdata, wd);
      chk1 ("addr_aok",   i_addr_ok | d_addr_ok, 1'b0);
      chk1 ("addr_busy",  busy, 1'b1);
      tick();
    end
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
    for (int k = 0; k <= ddly; k++) begin
      m_data_ok = (k == ddly);
      m_addr_ok = stray && (k == 0) && (ddly > 0);
      m_rdata   = (k == ddly) ? rd : $urandom;
      #1;
      chk1("data_mreq", m_req, 1'b0);
      chk1("data_aok",  i_addr_ok | d_addr_ok, 1'b0);
      chk1("data_dok",  i_data_ok | d_data_ok, 1'b0);
      chk1("data_busy", busy, 1'b1);
      tick();
    end
    m_data_ok = 1'b0;
    m_addr_ok = 1'b0;
    m_rdata   = $urandom;
    #1;
    chk1("resp_i_dok", i_data_ok, !exp_d);
    chk1("resp_d_dok", d_data_ok, exp_d);
    chk1("resp_aok",   i_addr_ok | d_addr_ok, 1'b0);
    chk1("resp_busy",  busy, 1'b1);
    if (exp_q.size() == 0) begin
      chk32("resp_queue", 32'(exp_q.size()), 32'd1);
    end else begin
      exp_word = exp_q.pop_front();
      chk32("resp_rdata", exp_d ? d_rdata : i_rdata, exp_word);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_addr = 32'h1FAF_0000; d_wdata = 32'h1234_5678;
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    // reset state with every request active
    #1;
    chk1 ("rst_i_aok",  i_addr_ok, 1'b0);
    chk1 ("rst_d_aok",  d_addr_ok, 1'b0);
    chk1 ("rst_i_dok",  i_data_ok, 1'b0);
    chk1 ("rst_d_dok",  d_data_ok, 1'b0);
    chk1 ("rst_mreq",   m_req, 1'b0);
    chk1 ("rst_mwr",    m_wr, 1'b0);
    chk32("rst_msize",  {30'h0, m_size}, 32'h0);
    chk32("rst_maddr",  m_addr, 32'h0);
    chk32("rst_mwdata", m_wdata, 32'h0);
    chk32("rst_i_rdata", i_rdata, 32'h0);
    chk32("rst_d_rdata", d_rdata, 32'h0);
    chk1 ("rst_ddev",   d_device, 1'b0);
    chk1 ("rst_busy",   busy, 1'b0);
    tick();
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; d_wdata = 32'h0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'h0;
    rst = 1'b0;
    tick();

    // fetch only, minimum latency
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    txn(1'b0, 32'hBFC0_0000, 1'b0, 2'b10, 32'h0, 32'h2408_0001, 0, 0, 1'b0, 1'b1);
    #1;
    chk1 ("f_idle_aok", i_addr_ok, 1'b0);
    chk32("f_hold",     i_rdata, 32'h2408_0001);
    tick();

    // simultaneous fetch and load: data first, fetch right after
    i_req = 1'b1; i_addr = 32'h0000_0100;
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h0000_0100; d_wdata = 32'h0;
    txn(1'b1, 32'h0000_0100, 1'b0, 2'b10, 32'h0, 32'h1111_2222, 0, 0, 1'b0, 1'b1);
    chk32("i_hold_across_d", i_rdata, 32'h2408_0001);
    i_addr = 32'h0000_0100;
    txn(1'b0, 32'h0000_0100, 1'b0, 2'b10, 32'h0, 32'h3333_4444, 0, 0, 1'b0, 1'b1);
    chk32("d_hold_across_i", d_rdata, 32'h1111_2222);

    // fairness: 6 loads with a fetch pending
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10;
    begin
      bit seq[7] = '{1, 1, 1, 1, 0, 1, 1};
      for (int n = 0; n < 7; n++) begin
        i_addr  = 32'hBFC0_0010 + 32'(n * 4);
        d_addr  = 32'h0000_0200 + 32'(n * 4);
        d_wdata = 32'h0;
        txn(seq[n], seq[n] ? 32'h0000_0200 + 32'(n * 4) : 32'hBFC0_0010 + 32'(n * 4),
            1'b0, 2'b10, 32'h0, 32'hA000_0000 + 32'(n), 0, 0, 1'b0, 1'b0);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // store into device space, then a byte load outside it
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_addr = 32'h1FAF_F000; d_wdata = 32'hDEAD_BEEF;
    txn(1'b1, 32'h1FAF_F000, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 0, 1'b0, 1'b1);
    chk1("st_device", d_device, 1'b1);
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0000; d_wdata = 32'h0;
    txn(1'b1, 32'h0000_0000, 1'b0, 2'b00, 32'h0, 32'h0000_00C3, 0, 0, 1'b0, 1'b1);
    chk1("ld_device", d_device, 1'b0);

    // slow address phase, slow data phase, stray handshakes
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'b01; d_addr = 32'h1FAF_0042; d_wdata = 32'h0;
    txn(1'b1, 32'h1FAF_0042, 1'b0, 2'b01, 32'h0, 32'h7E57_0033, 5, 2, 1'b1, 1'b1);
    chk1("slow_device", d_device, 1'b1);

    // stray pulses while idle change nothing
    m_addr_ok = 1'b1; m_data_ok = 1'b1;
    #1;
    chk1("stray_idle_busy", busy, 1'b0);
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    #1;
    chk1("stray_idle_busy2", busy, 1'b0);
    chk1("stray_idle_dok",   i_data_ok | d_data_ok, 1'b0);
    tick();

    // reset during DATA aborts the fetch
    i_req = 1'b1; i_addr = 32'hBFC0_0020;
    #1;
    chk1("ab_grant", i_addr_ok, 1'b1);
    tick();
    i_req = 1'b0; m_addr_ok = 1'b1;
    #1;
    chk1("ab_addr_mreq", m_req, 1'b1);
    tick();
    m_addr_ok = 1'b0;
    #1;
    chk1("ab_data_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk1 ("ab_rst_mreq", m_req, 1'b0);
    chk1 ("ab_rst_busy", busy, 1'b0);
    chk32("ab_rst_maddr", m_addr, 32'h0);
    m_data_ok = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    m_data_ok = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1 ("ab_no_dok",  i_data_ok | d_data_ok, 1'b0);
      chk1 ("ab_idle",    busy, 1'b0);
      chk32("ab_i_rdata", i_rdata, 32'h0);
      tick();
    end
    i_req = 1'b1; i_addr = 32'hBFC0_0030;
    txn(1'b0, 32'hBFC0_0030, 1'b0, 2'b10, 32'h0, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b1);

    chk32("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
